// File: rtl/param_up_dn_counter_if.sv
// Bundles the load/step/limit controls and the count/status outputs of param_up_dn_counter.
// The master modport drives the controls and the slave modport is the counter itself.
interface param_up_dn_counter_if #(
  parameter int unsigned WIDTH = 5
) ();
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] min_lim;
  logic [WIDTH-1:0] max_lim;
  logic [WIDTH-1:0] counter;
  logic             load;
  logic             up;
  logic             down;
  logic             enable;
  logic             high;
  logic             low;
  logic             ovf;
  logic             udf;
  logic             cfg_err;

  modport master (
    output in_val, step, min_lim, max_lim, load, up, down, enable,
    input  counter, high, low, ovf, udf, cfg_err
  );

  modport slave (
    input  in_val, step, min_lim, max_lim, load, up, down, enable,
    output counter, high, low, ovf, udf, cfg_err
  );
endinterface

// File: rtl/param_up_dn_counter.sv
// Bounded load/up/down counter with a runtime step, a saturate-or-wrap mode and registered
// overflow/underflow pulses. The limits are inclusive, and the counter is forced back inside them.
module param_up_dn_counter #(
  parameter int unsigned      WIDTH   = 5,
  parameter bit               WRAP    = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  param_up_dn_counter_if.slave bus
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             cfg_err;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             up_cross;
  logic             dn_cross;
  logic             above;
  logic             below;

  // The extra bit keeps carries and borrows visible instead of wrapping modulo 2**WIDTH.
  always_comb begin
    cfg_err  = bus.min_lim > bus.max_lim;
    sum      = {1'b0, counter_q} + {1'b0, bus.step};
    diff     = {1'b0, counter_q} - {1'b0, bus.step};
    up_cross = sum > {1'b0, bus.max_lim};
    dn_cross = diff[WIDTH] || (diff[WIDTH-1:0] < bus.min_lim);
    above    = counter_q > bus.max_lim;
    below    = counter_q < bus.min_lim;
  end

  always_comb begin
    counter_d = counter_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    if (!cfg_err) begin
      if (bus.load) begin
        if (bus.in_val > bus.max_lim) begin
          counter_d = bus.max_lim;
        end else if (bus.in_val < bus.min_lim) begin
          counter_d = bus.min_lim;
        end else begin
          counter_d = bus.in_val;
        end
      end else if (bus.enable && (above || below)) begin
        // Limits moved under the counter: snap to the nearest bound and drop this cycle's request.
        counter_d = above ? bus.max_lim : bus.min_lim;
      end else if (bus.enable && bus.down) begin
        if (dn_cross) begin
          counter_d = WRAP ? bus.max_lim : bus.min_lim;
          udf_d     = 1'b1;
        end else begin
          counter_d = diff[WIDTH-1:0];
        end
      end else if (bus.enable && bus.up) begin
        if (up_cross) begin
          counter_d = WRAP ? bus.min_lim : bus.max_lim;
          ovf_d     = 1'b1;
        end else begin
          counter_d = sum[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= RST_VAL;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign bus.counter = counter_q;
  assign bus.high    = counter_q == bus.max_lim;
  assign bus.low     = counter_q == bus.min_lim;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;
  assign bus.cfg_err = cfg_err;

endmodule
